// File: rtl/snake_engine.sv
// Snake game-logic writer for the play-area bitmap: keeps the body in a circular
// buffer and, per tick, moves the head, checks collisions by read-back, and erases the tail.
`timescale 1ns/1ps
module snake_engine #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int MAX_LEN   = 64,
    parameter int START_LEN = 4,
    parameter int START_X   = 40,
    parameter int START_Y   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] dir_in,
    input  logic [6:0] food_x,
    input  logic [5:0] food_y,
    output logic [6:0] ram_x,
    output logic [5:0] ram_y,
    output logic       ram_we,
    output logic       ram_wdata,
    input  logic       ram_rdata,
    output logic       busy,
    output logic       ate,
    output logic       dead,
    output logic [6:0] length
);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int X0 = START_X - START_LEN + 1;
    localparam logic signed [7:0] GW = 8'(GRID_W);
    localparam logic signed [7:0] GH = 8'(GRID_H);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_WHEAD = 3'd5;
    localparam logic [2:0] S_ERASE = 3'd6;
    localparam logic [2:0] S_DEAD  = 3'd7;

    logic [2:0]        state;
    logic [7:0]        init_cnt, len;
    logic [PW-1:0]     head_ptr, tail_ptr;
    logic [1:0]        cur_dir, req_dir, eff_dir;
    logic signed [7:0] hx, hy, calc_x, calc_y, nx, ny;
    logic              calc_wall, calc_food, wall, on_food, grow;
    logic              next_is_tail, hit;
    logic [6:0]        tail_x, seg_x;
    logic [5:0]        tail_y;

    logic [6:0]        body_x [MAX_LEN];
    logic [5:0]        body_y [MAX_LEN];
    logic              body_we;
    logic [PW-1:0]     body_wa;
    logic [6:0]        body_wx;
    logic [5:0]        body_wy;

    assign eff_dir = (req_dir == (cur_dir ^ 2'd2)) ? cur_dir : req_dir;
    assign hx      = $signed({1'b0, body_x[head_ptr]});
    assign hy      = $signed({2'b0, body_y[head_ptr]});
    assign seg_x   = 7'(X0) + init_cnt[6:0];

    always_comb begin
        calc_x = hx;
        calc_y = hy;
        case (eff_dir)
            2'd0:    calc_y = hy - 8'sd1;
            2'd1:    calc_x = hx + 8'sd1;
            2'd2:    calc_y = hy + 8'sd1;
            default: calc_x = hx - 8'sd1;
        endcase
    end

    assign calc_wall = (calc_x < 8'sd0) || (calc_x >= GW) || (calc_y < 8'sd0) || (calc_y >= GH);
    assign calc_food = (calc_x == $signed({1'b0, food_x})) && (calc_y == $signed({2'b0, food_y}));

    // Stepping into the cell the tail is about to vacate is legal unless we grow.
    assign next_is_tail = (nx == $signed({1'b0, body_x[tail_ptr]})) &&
                          (ny == $signed({2'b0, body_y[tail_ptr]}));
    assign hit    = wall | (ram_rdata & ~(next_is_tail & ~grow));
    assign ate    = (state == S_CHECK) & on_food & ~hit;
    assign length = len[6:0];

    always_comb begin
        body_we = 1'b0;
        body_wa = init_cnt[PW-1:0];
        body_wx = seg_x;
        body_wy = 6'(START_Y);
        if (state == S_INIT && init_cnt < 8'(START_LEN)) begin
            body_we = 1'b1;
        end else if (state == S_CHECK && !hit) begin
            body_we = 1'b1;
            body_wa = head_ptr + PW'(1);
            body_wx = nx[6:0];
            body_wy = ny[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (body_we) begin
            body_x[body_wa] <= body_wx;
            body_y[body_wa] <= body_wy;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            len       <= '0;
            head_ptr  <= PW'(START_LEN - 1);
            tail_ptr  <= '0;
            cur_dir   <= 2'd1;
            req_dir   <= 2'd1;
            nx        <= '0;
            ny        <= '0;
            wall      <= 1'b0;
            on_food   <= 1'b0;
            grow      <= 1'b0;
            tail_x    <= '0;
            tail_y    <= '0;
            ram_x     <= '0;
            ram_y     <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= 1'b0;
            busy      <= 1'b0;
            dead      <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt < 8'(START_LEN)) begin
                        ram_x     <= seg_x;
                        ram_y     <= 6'(START_Y);
                        ram_we    <= 1'b1;
                        ram_wdata <= 1'b1;
                        busy      <= 1'b1;
                        init_cnt  <= init_cnt + 8'd1;
                    end else begin
                        ram_we    <= 1'b0;
                        ram_wdata <= 1'b0;
                        busy      <= 1'b0;
                        len       <= 8'(START_LEN);
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        req_dir <= dir_in;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    cur_dir <= eff_dir;
                    nx      <= calc_x;
                    ny      <= calc_y;
                    wall    <= calc_wall;
                    on_food <= calc_food;
                    grow    <= calc_food && (len < 8'(MAX_LEN));
                    ram_x   <= calc_x[6:0];
                    ram_y   <= calc_y[5:0];
                    ram_we  <= 1'b0;
                    state   <= S_READ;
                end
                S_READ: state <= S_CHECK;
                S_CHECK: begin
                    // Latch the tail now: at full length the head write reuses its slot.
                    tail_x <= body_x[tail_ptr];
                    tail_y <= body_y[tail_ptr];
                    if (hit) begin
                        dead  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DEAD;
                    end else begin
                        head_ptr  <= head_ptr + PW'(1);
                        ram_x     <= nx[6:0];
                        ram_y     <= ny[5:0];
                        ram_we    <= 1'b1;
                        ram_wdata <= 1'b1;
                        state     <= S_WHEAD;
                    end
                end
                S_WHEAD: begin
                    if (grow) begin
                        ram_we    <= 1'b0;
                        ram_wdata <= 1'b0;
                        len       <= len + 8'd1;
                    end else if (tail_x == nx[6:0] && tail_y == ny[5:0]) begin
                        ram_we    <= 1'b0;
                        ram_wdata <= 1'b0;
                        tail_ptr  <= tail_ptr + PW'(1);
                    end else begin
                        ram_x     <= tail_x;
                        ram_y     <= tail_y;
                        ram_we    <= 1'b1;
                        ram_wdata <= 1'b0;
                        tail_ptr  <= tail_ptr + PW'(1);
                    end
                    state <= S_ERASE;
                end
                S_ERASE: begin
                    ram_we    <= 1'b0;
                    ram_wdata <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
